// File: rtl/pe_mul_arbiter.sv
// pe_mul_arbiter: lets two requesters share one external fixed-latency multiplier.
// An arbiter accepts at most one operand pair per cycle and issues it on the next
// cycle. A tag pipeline follows each issue through the multiplier, so the product
// can be returned to the requester that owns it.
//
// Ports
//   clk, reset               clock; synchronous active-high reset
//   en                       grant enable (in-flight work still drains when low)
//   prio_fixed               1: req0 has strict priority, 0: round-robin
//   reqN_valid/ready/a/b     operand handshake per requester (ready is combinational)
//   mul_en, mul_a, mul_b     registered issue to the shared multiplier
//   mul_p                    product, valid LAT cycles after mul_en
//   resN_valid, resN_p       registered result per requester, no backpressure
//   inflight                 operations accepted but not yet returned
//   idle                     no operation in flight and no issue this cycle
module pe_mul_arbiter #(
  parameter int unsigned DW  = 12,
  parameter int unsigned LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              prio_fixed,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [DW-1:0]     req0_a,
  input  logic [DW-1:0]     req0_b,
  input  logic [DW-1:0]     req1_a,
  input  logic [DW-1:0]     req1_b,
  output logic              mul_en,
  output logic [DW-1:0]     mul_a,
  output logic [DW-1:0]     mul_b,
  input  logic [2*DW-1:0]   mul_p,
  output logic              res0_valid,
  output logic              res1_valid,
  output logic [2*DW-1:0]   res0_p,
  output logic [2*DW-1:0]   res1_p,
  output logic [3:0]        inflight,
  output logic              idle
);

  localparam int unsigned PW = 2 * DW;
  localparam int unsigned IW = 4;

  // Arbitration
  logic gnt0;
  logic gnt1;
  logic xfer;

  // State
  logic          last_grant_q, last_grant_d;
  logic          mul_en_q,     mul_en_d;
  logic          mul_id_q,     mul_id_d;
  logic [DW-1:0] mul_a_q,      mul_a_d;
  logic [DW-1:0] mul_b_q,      mul_b_d;
  logic [LAT-1:0] tag_v_q,     tag_v_d;
  logic [LAT-1:0] tag_id_q,    tag_id_d;
  logic          res0_valid_q, res0_valid_d;
  logic          res1_valid_q, res1_valid_d;
  logic [PW-1:0] res0_p_q,     res0_p_d;
  logic [PW-1:0] res1_p_q,     res1_p_d;
  logic [IW-1:0] inflight_q,   inflight_d;

  logic exit_v;
  logic exit_id;
  logic ret;

  // Grant: strict priority or round-robin on last_grant; nothing while disabled or in reset
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en && !reset) begin
      if (req0_valid && req1_valid) begin
        if (prio_fixed || last_grant_q) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end else if (req0_valid) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Grants only fire on a valid request, so a grant is a transfer
  assign xfer = gnt0 | gnt1;

  // The tag entering stage 0 one cycle after mul_en exits at stage LAT-1, alongside mul_p
  assign exit_v  = tag_v_q[LAT-1];
  assign exit_id = tag_id_q[LAT-1];
  assign ret     = res0_valid_q | res1_valid_q;

  // Next-state logic
  always_comb begin
    last_grant_d = last_grant_q;
    mul_en_d     = xfer;
    mul_id_d     = mul_id_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    tag_v_d      = tag_v_q;
    tag_id_d     = tag_id_q;
    res0_valid_d = 1'b0;
    res1_valid_d = 1'b0;
    res0_p_d     = res0_p_q;
    res1_p_d     = res1_p_q;
    inflight_d   = inflight_q;

    if (gnt0) begin
      last_grant_d = 1'b0;
      mul_id_d     = 1'b0;
      mul_a_d      = req0_a;
      mul_b_d      = req0_b;
    end else if (gnt1) begin
      last_grant_d = 1'b1;
      mul_id_d     = 1'b1;
      mul_a_d      = req1_a;
      mul_b_d      = req1_b;
    end

    tag_v_d[0]  = mul_en_q;
    tag_id_d[0] = mul_id_q;
    for (int i = 1; i < int'(LAT); i++) begin
      tag_v_d[i]  = tag_v_q[i-1];
      tag_id_d[i] = tag_id_q[i-1];
    end

    // mul_p is only captured when a tag is exiting
    if (exit_v) begin
      if (exit_id) begin
        res1_valid_d = 1'b1;
        res1_p_d     = mul_p;
      end else begin
        res0_valid_d = 1'b1;
        res0_p_d     = mul_p;
      end
    end

    // Accept and return in the same cycle cancel out
    if (xfer && !ret) begin
      inflight_d = inflight_q + IW'(1);
    end else if (!xfer && ret) begin
      inflight_d = inflight_q - IW'(1);
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      mul_en_q     <= 1'b0;
      mul_id_q     <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      tag_v_q      <= '0;
      tag_id_q     <= '0;
      res0_valid_q <= 1'b0;
      res1_valid_q <= 1'b0;
      res0_p_q     <= '0;
      res1_p_q     <= '0;
      inflight_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      mul_en_q     <= mul_en_d;
      mul_id_q     <= mul_id_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      tag_v_q      <= tag_v_d;
      tag_id_q     <= tag_id_d;
      res0_valid_q <= res0_valid_d;
      res1_valid_q <= res1_valid_d;
      res0_p_q     <= res0_p_d;
      res1_p_q     <= res1_p_d;
      inflight_q   <= inflight_d;
    end
  end

  // Outputs
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign mul_en     = mul_en_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign res0_valid = res0_valid_q;
  assign res1_valid = res1_valid_q;
  assign res0_p     = res0_p_q;
  assign res1_p     = res1_p_q;
  assign inflight   = inflight_q;
  assign idle       = (inflight_q == '0) && !mul_en_q;

endmodule

// File: doc/pe_mul_arbiter.md
PE_MUL_ARBITER -- requirements
Module: pe_mul_arbiter

Interface
REQ-001 Parameters (name, default, meaning): DW, 12, operand width; LAT, 4, fixed latency of the external multiplier (mul_en to mul_p valid), legal range 1..12.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 en  in  1  grant enable; 0 blocks new grants, in-flight work still drains.
REQ-005 prio_fixed  in  1  1 = requester 0 has strict priority; 0 = round-robin.
REQ-006 req0_valid, req1_valid  in  1 each  operand pair offered.
REQ-007 req0_ready, req1_ready  out  1 each  operand pair accepted this cycle.
REQ-008 req0_a, req0_b, req1_a, req1_b  in  DW each  operands.
REQ-009 mul_en  out  1  issue strobe to the shared multiplier (Dadda-tree datapath).
REQ-010 mul_a, mul_b  out  DW each  issued operands.
REQ-011 mul_p  in  2*DW  product, valid exactly LAT cycles after the matching mul_en.
REQ-012 res0_valid, res1_valid  out  1 each  result strobe per requester; no backpressure.
REQ-013 res0_p, res1_p  out  2*DW each  product returned to the owning requester.
REQ-014 inflight  out  4  operations accepted but not yet returned.
REQ-015 idle  out  1  high when inflight==0 and mul_en==0.

Function
REQ-016 Handshake: a transfer occurs on a cycle with reqN_valid & reqN_ready; at most one of req0_ready/req1_ready is high per cycle.
REQ-017 reqN_ready is combinational from en, both valids, prio_fixed and the last-grant register; ready is 0 whenever en==0 or reset==1.
REQ-018 prio_fixed=1: grant req0 if req0_valid, else req1 if req1_valid.
REQ-019 prio_fixed=0: both valid -> grant the requester not granted last; single valid -> grant it.
REQ-020 last_grant updates only on a transfer; reset value 1, so req0 wins the first contention.
REQ-021 Issue: a transfer in cycle T drives mul_en=1 and registered mul_a/mul_b in cycle T+1; no transfer -> mul_en=0, mul_a/mul_b hold their previous values.
REQ-022 Throughput: one issue per cycle sustained; back-to-back transfers from the same or alternating requesters are legal.
REQ-023 Tag pipeline: a LAT-deep shift register carries {valid, id} aligned with each mul_en; the tag leaves the pipeline in the cycle mul_p is valid (T+1+LAT).
REQ-024 Return: res<id>_p <= mul_p and res<id>_valid <= 1 in cycle T+2+LAT (total latency LAT+2 from transfer); the other requester's valid is 0 that cycle.
REQ-025 resN_p holds its last value while resN_valid==0; mul_p is ignored when no tag is exiting.
REQ-026 Ordering: results return in issue order; the id is never lost or reordered.
REQ-027 inflight: +1 on a transfer, -1 on any resN_valid; both in one cycle -> unchanged; max value LAT+2, never wraps.
REQ-028 en deasserted mid-stream: no new transfers; all accepted operations still return with normal latency.
REQ-029 Product arithmetic is not checked or modified by this block; width is passed through unchanged.

Reset
REQ-030 reset in any cycle, including with operations in flight, clears all tag-pipeline valids, inflight=0 and last_grant=1, and drives mul_en=0, res0_valid=0, res1_valid=0 on the following cycle; in-flight results are discarded, never emitted.
REQ-031 Registered data outputs (mul_a, mul_b, res0_p, res1_p) reset to 0; idle=1 after reset.

Verification
REQ-032 Single op: LAT=4, req0 a=12'd3329 b=12'd2 transferred at T -> mul_en at T+1, res0_valid at T+6 with res0_p=6658; res1_valid stays 0.
REQ-033 Round-robin: both valid for 4 cycles, prio_fixed=0 -> grants 0,1,0,1; results return alternating res0/res1 in the same order, 6 cycles after each transfer.
REQ-034 Strict priority: prio_fixed=1, both valid for 5 cycles -> req1_ready never high; req0 gets 5 transfers; after req0_valid drops, req1 granted next cycle.
REQ-035 Full pipe plus simultaneous events: 10 back-to-back transfers -> inflight peaks at 6, holds 6 while transfer and return coincide, reaches 0 and idle=1 after the last result.
REQ-036 en drop: en=0 for 3 cycles with 2 operations in flight -> no ready, both results return on time, inflight 2->0.
REQ-037 Reset mid-flight: reset pulse 2 cycles after 3 transfers -> no resN_valid ever asserted for those operations, inflight=0, and the next contention is granted to req0.
